// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one recv_valid pulse per good frame.
// Optional macro UART_RX_FRAME_ERR_EN adds the frame_err pulse output.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       recv_valid,
    output logic [7:0] recv_data
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = ($clog2(DIV) > 14) ? $clog2(DIV) : 14;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_next;
    logic [1:0]         sync_ff;
    logic               rx_s;
    logic               rx_prev;
    logic [CNT_W-1:0]   baud_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift_reg;
    logic               full_tick;
    logic               half_tick;
    logic               shift_en;
    logic               accept;

    assign rx_s      = sync_ff[1];
    assign full_tick = (baud_cnt == CNT_W'(DIV - 1));
    assign half_tick = (baud_cnt == CNT_W'(HALF - 1));

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s && rx_prev)
                    state_next = START;
            end
            START: begin
                if (half_tick)
                    state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (full_tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_next = STOP;
                end
            end
            STOP: begin
                // Leaving mid stop bit lets a zero-gap next start edge be caught.
                if (full_tick) begin
                    state_next = IDLE;
                    accept     = rx_s;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff    <= '1;
            rx_prev    <= 1'b1;
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            recv_valid <= 1'b0;
            recv_data  <= '0;
        end else begin
            sync_ff    <= {sync_ff[0], rx};
            rx_prev    <= rx_s;
            state      <= state_next;
            recv_valid <= accept;
            if (accept)
                recv_data <= shift_reg;

            if (state_next != state || full_tick)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state_next != state)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 1'b1;

            if (shift_en)
                shift_reg <= {rx_s, shift_reg[7:1]};
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            frame_err <= 1'b0;
        else
            frame_err <= (state == STOP) && full_tick && !rx_s;
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx; a byte queue models what the line should deliver.
// Runs at a fast baud so each bit is 16 clocks.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 100_000_000;
    localparam int unsigned BAUD     = 6_250_000;
    localparam int unsigned DIV      = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       recv_valid;
    logic [7:0] recv_data;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
    int         ferr_count = 0;
    int         ferr_exp   = 0;
`endif

    int         n_checks    = 0;
    int         n_errors    = 0;
    int         pulse_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_data  = 8'h00;
    logic       prev_valid  = 1'b0;
    time        t_start     = 0;
    time        t_pulse     = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .recv_valid(recv_valid),
        .recv_data (recv_data)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (recv_valid) begin
            pulse_count++;
            t_pulse = $time;
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0)
                check("spurious_valid", 32'd1, 32'd0);
            else
                check("rx_byte", 32'(recv_data), 32'(exp_q.pop_front()));
        end
        prev_valid = recv_valid;
`ifdef UART_RX_FRAME_ERR_EN
        if (frame_err)
            ferr_count++;
`endif
    end

    task automatic hold(input logic level, input int unsigned clks);
        rx = level;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_ok, input int unsigned gap_bits);
        if (stop_ok) begin
            exp_q.push_back(d);
            model_data = d;
        end
`ifdef UART_RX_FRAME_ERR_EN
        else
            ferr_exp++;
`endif
        t_start = $time;
        hold(1'b0, DIV);
        for (int i = 0; i < 8; i++)
            hold(d[i], DIV);
        hold(stop_ok, DIV);
        hold(1'b1, gap_bits * DIV);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_valid", 32'(recv_valid), 32'd0);
        check("reset_data", 32'(recv_data), 32'h00);
`ifdef UART_RX_FRAME_ERR_EN
        check("reset_frame_err", 32'(frame_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_data = 8'h00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          p0;
        int          lat;
        int          diff;
        logic [7:0]  word[6];
        logic [7:0]  v;
        logic [7:0]  d;
        logic        ok;
        int unsigned gap;

        rx  = 1'b1;
        rst = 1'b0;
        do_reset();
        hold(1'b1, 2 * DIV);

        // Single byte with latency measured from the start edge.
        p0 = pulse_count;
        send_byte(8'h73, 1'b1, 2);
        check("t1_pulses", 32'(pulse_count - p0), 32'd1);
        lat  = int'((t_pulse - t_start) / 10);
        diff = 2 * lat - 19 * int'(DIV);
        check("t1_latency_in_window", 32'(diff <= 6 && diff >= -6), 32'd1);
        check("t1_data_held", 32'(recv_data), 32'(model_data));

        // Back-to-back frames with zero idle gap.
        word = '{8'h73, 8'h74, 8'h6F, 8'h70, 8'h0D, 8'h0A};
        p0 = pulse_count;
        for (int i = 0; i < 6; i++)
            send_byte(word[i], 1'b1, (i == 5) ? 2 : 0);
        check("t2_pulses", 32'(pulse_count - p0), 32'd6);

        // Glitch shorter than half a bit is rejected.
        p0 = pulse_count;
        hold(1'b0, 3);
        hold(1'b1, 2 * DIV);
        check("t3_glitch_pulses", 32'(pulse_count - p0), 32'd0);
        send_byte(8'h31, 1'b1, 2);
        check("t3_after_glitch_pulses", 32'(pulse_count - p0), 32'd1);

        // Bad stop bit: byte dropped, previous data held.
        p0 = pulse_count;
        send_byte(8'h32, 1'b0, 2);
        check("t4_pulses", 32'(pulse_count - p0), 32'd0);
        check("t4_data_held", 32'(recv_data), 32'h31);

        // One-cycle reset during data bit 4 of 0x55.
        p0 = pulse_count;
        v  = 8'h55;
        hold(1'b0, DIV);
        for (int i = 0; i < 4; i++)
            hold(v[i], DIV);
        hold(v[4], DIV / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_data = 8'h00;
        hold(v[4], DIV / 2 - 1);
        for (int i = 5; i < 8; i++)
            hold(v[i], DIV);
        hold(1'b1, DIV);
        check("t5_pulses", 32'(pulse_count - p0), 32'd0);
        check("t5_data_cleared", 32'(recv_data), 32'h00);
        // The falling edge into bit 5 starts a new frame: bits 6,7, stop and idle ones form its byte.
        d = {6'b111111, v[7], v[6]};
        exp_q.push_back(d);
        model_data = d;
        hold(1'b1, 8 * DIV);
        check("t5_resync_pulses", 32'(pulse_count - p0), 32'd1);
        send_byte(8'hAA, 1'b1, 2);
        check("t5_next_frame", 32'(recv_data), 32'hAA);

        // Line stuck low: a single error frame, then no retriggering.
        do_reset();
        p0 = pulse_count;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_exp++;
`endif
        hold(1'b0, 20 * DIV);
        hold(1'b1, 2 * DIV);
        check("t6_stuck_pulses", 32'(pulse_count - p0), 32'd0);
        send_byte(8'h70, 1'b1, 2);
        check("t6_next_frame", 32'(recv_data), 32'h70);

        // Random bytes, random gaps, occasional framing errors.
        for (int i = 0; i < 30; i++) begin
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 5) != 0);
            gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send_byte(d, ok, gap);
            check("rand_data_held", 32'(recv_data), 32'(model_data));
        end

        hold(1'b1, 2 * DIV);
        for (int i = 0; i < 20 * int'(DIV) && exp_q.size() != 0; i++)
            @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
        check("frame_err_count", 32'(ferr_count), 32'(ferr_exp));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver that converts the serial line from the host into byte strobes. It is the stage directly upstream of the command-string recogniser and drives that block's recv_valid/recv_data inputs. It runs on the single 100 MHz system clock and emits exactly one valid pulse per correctly framed byte.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD, 9600, line rate in bit/s.
DIV, CLK_FREQ/BAUD (10416 at the defaults), local derived value: clocks per bit.
HALF, DIV/2 (5208), local derived value: clocks to mid-bit.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
rx  input  1  asynchronous serial line, idle high.
recv_valid  output  1  one-cycle pulse when a byte is accepted.
recv_data  output  8  received byte; valid while recv_valid=1, held until the next accepted byte.
frame_err  output  1  present only with UART_RX_FRAME_ERR_EN; see Optional Feature.

Behaviour:
- Reset, synchronous and active-high: recv_valid=0, recv_data=8'h00, both synchroniser flops=1, prev-level flop=1, state=IDLE, bit and baud counters=0, frame_err=0.
- rx passes through a 2-flop synchroniser; rx_s is the second flop's output.
- A falling edge is rx_s=0 while its previous-cycle value was 1. The cycle in which it is seen is T0.
- Baud counter: 14 bits minimum. It counts 0..DIV-1 and wraps. It clears on every state entry.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on a falling edge go to START. A line stuck low generates no edge, so it never re-arms.
- START: sample rx_s at T0+HALF.
  - If 1, it is a glitch: return to IDLE with no output.
  - If 0, go to DATA.
- DATA: sample at T0+HALF+k*DIV for k=1..8.
  - Bits arrive LSB first into a shift register: shift right, MSB in.
  - Bit counter 0..7; after the 8th sample go to STOP.
- STOP: sample at T0+HALF+9*DIV.
  - If 1: in the next cycle recv_data<=shift register and recv_valid=1 for exactly one cycle. Return to IDLE.
  - If 0 (framing error): the byte is discarded. recv_valid stays 0 and recv_data is unchanged. Return to IDLE.
- Back-to-back frames: IDLE is re-entered mid stop bit, so the next start edge, even with zero idle gap, is captured.
- rst asserted mid-frame: the partial byte is dropped and no pulse is emitted. After rst is released, the next falling edge starts a fresh frame.
- recv_valid never stays high for two consecutive cycles.
- No flow control; the downstream block must accept every pulse.

Optional Feature:
Macro: UART_RX_FRAME_ERR_EN
- Defined: adds the frame_err output port.
  - It pulses 1 for one cycle, in the same cycle recv_valid would have fired, when the stop sample is 0.
  - It is 0 otherwise and 0 after reset.
- Not defined: the port does not exist and framing errors are dropped silently. All other behaviour is identical.

Test Plan:
1. Reset, then send 0x73 ('s') at 9600 baud, 104167 ns/bit -> exactly one recv_valid pulse, recv_data=8'h73, pulse within 9.5 bit times (±3 clk) of the start edge.
2. Send "stop" followed by 8'h0D, 8'h0A back-to-back with zero idle gap -> 6 pulses carrying 8'h73, 8'h74, 8'h6F, 8'h70, 8'h0D, 8'h0A in order; no missed or duplicate pulses.
3. Drive a 2000 ns low glitch on an idle line -> no recv_valid; a following 0x31 frame is received correctly.
4. Send 0x32 with the stop bit forced to 0 -> no recv_valid and recv_data keeps its prior value. With UART_RX_FRAME_ERR_EN, frame_err pulses once.
5. Assert rst for 1 clk during data bit 4 of 0x55 -> no pulse and recv_data=8'h00. The next frame 0xAA gives recv_data=8'hAA.
6. Hold rx low for 20 bit times after reset, then release -> at most one error frame and no valid pulse, i.e. no repeated triggering. A subsequent 0x70 frame is received correctly.
